// File: rtl/cdb_writeback_arbiter.sv
// cdb_writeback_arbiter: round-robin writeback arbiter feeding a registered CDB stage.
// Defining CDB_STATS_EN adds saturating grant/stall counters.
module cdb_writeback_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [NUM_UNITS-1:0]            unitValid_i,
    input  logic [NUM_UNITS*64-1:0]         unitVal_i,
    input  logic [NUM_UNITS*10-1:0]         unitCommands_i,
    input  logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i,
    input  logic [NUM_UNITS*4-1:0]          unitFlags_i,
    output logic [NUM_UNITS-1:0]            canGo_o,
    input  logic                            cdbReady_i,
    output logic                            cdbValid_o,
    output logic [63:0]                     cdbVal_o,
    output logic [9:0]                      cdbCommands_o,
    output logic [ROBsizeLog-1:0]           cdbTag_o,
    output logic [3:0]                      cdbFlags_o
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]                     statGrants_o,
    output logic [31:0]                     statStalls_o
`endif
);
    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]           r_state;
    logic [PW-1:0]        r_rr;
    logic [NUM_UNITS-1:0] r_granted_last;
    logic [NUM_UNITS-1:0] w_req;
    logic                 w_free;
    logic                 w_found;
    logic [PW-1:0]        w_win;

    // Units granted last cycle are masked in case they sample canGo late.
    always_comb begin
        w_req   = unitValid_i & ~r_granted_last;
        w_free  = (r_state == EMPTY) | cdbReady_i;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= NUM_UNITS; i++) begin
            if (!w_found && w_req[PW'((int'(r_rr) + i) % NUM_UNITS)]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_rr) + i) % NUM_UNITS);
            end
        end
        canGo_o = (reset_n_i && w_free && w_found) ? NUM_UNITS'(1) << w_win : '0;
    end

    assign cdbValid_o = (r_state == FULL);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= EMPTY;
            r_rr           <= PW'(NUM_UNITS - 1);
            r_granted_last <= '0;
            cdbVal_o       <= '0;
            cdbCommands_o  <= '0;
            cdbTag_o       <= '0;
            cdbFlags_o     <= '0;
        end else begin
            r_granted_last <= canGo_o;
            if (|canGo_o) begin
                r_state       <= FULL;
                r_rr          <= w_win;
                cdbVal_o      <= unitVal_i[w_win*64 +: 64];
                cdbCommands_o <= unitCommands_i[w_win*10 +: 10];
                cdbTag_o      <= unitTag_i[w_win*ROBsizeLog +: ROBsizeLog];
                cdbFlags_o    <= unitFlags_i[w_win*4 +: 4];
            end else if (cdbReady_i) begin
                r_state <= EMPTY;
            end
        end
    end

`ifdef CDB_STATS_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            statGrants_o <= '0;
            statStalls_o <= '0;
        end else begin
            if (|canGo_o && statGrants_o != '1)
                statGrants_o <= statGrants_o + 32'd1;
            if (cdbValid_o && !cdbReady_i && |unitValid_i && statStalls_o != '1)
                statStalls_o <= statStalls_o + 32'd1;
        end
    end
`endif
endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview:
Completion-side partner of the execute stages. It collects finished results from NUM_UNITS execute stages (ALU, multiplier, divider, ...) over their valid_o/canGo_i handshake. Each cycle it grants at most one unit, round-robin, and broadcasts that unit's result from a registered common data bus (CDB) stage toward the ROB and reservation stations, with backpressure from cdbReady_i.

Parameters:
NUM_UNITS, 4, number of execute stages arbitrated (2..8)
ROBsize, 32, ROB entries
ROBsizeLog, $clog2(ROBsize+1), tag width

Ports:
clk_i  in  1  clock, all state on rising edge
reset_n_i  in  1  asynchronous active-low reset
unitValid_i  in  NUM_UNITS  bit k = unit k holds a finished result (its valid_o)
unitVal_i  in  NUM_UNITS*64  unit k result at [64k+63:64k]
unitCommands_i  in  NUM_UNITS*10  unit k commands at [10k+9:10k]
unitTag_i  in  NUM_UNITS*ROBsizeLog  unit k ROB tag
unitFlags_i  in  NUM_UNITS*4  unit k flags
canGo_o  out  NUM_UNITS  one-hot grant; bit k drives unit k canGo_i
cdbReady_i  in  1  ROB/RS accept CDB word this cycle
cdbValid_o  out  1  CDB word valid
cdbVal_o  out  64  broadcast value
cdbCommands_o  out  10  broadcast commands
cdbTag_o  out  ROBsizeLog  broadcast ROB tag
cdbFlags_o  out  4  broadcast flags

Behaviour:
- Reset (async assert, sync release): cdbValid_o=0, cdbVal_o/cdbCommands_o/cdbTag_o/cdbFlags_o=0, rrPtr_r=NUM_UNITS-1 so unit 0 has first priority. canGo_o=0 while reset_n_i=0.
- Output register states: EMPTY (cdbValid_o=0) and FULL (cdbValid_o=1).
- Slot free: free = ~cdbValid_o | cdbReady_i.
- canGo_o, combinational: if free and unitValid_i!=0, the single winner bit is set. Otherwise canGo_o=0.
- The winner is the first set bit of unitValid_i searching rrPtr_r+1, rrPtr_r+2, ..., wrapping modulo NUM_UNITS.
- A grant is never given to a unit with unitValid_i=0. canGo_o is always one-hot or zero.
- On a grant edge:
  - the winner's val/commands/tag/flags load into the output register;
  - cdbValid_o goes to 1 the next cycle, so latency is 1 cycle from grant to broadcast;
  - rrPtr_r becomes the winner index.
- Drain with no new grant (FULL, cdbReady_i=1, no requester): cdbValid_o goes to 0 next cycle.
- Simultaneous drain and load (FULL, cdbReady_i=1, requester present): the old word retires and the new word loads in the same edge. Sustains 1 result/cycle.
- FULL and cdbReady_i=0: output register holds all fields unchanged, canGo_o=0. No unit is dropped; units keep valid_o high.
- Unit contract: a unit deasserts valid the cycle after canGo. The arbiter does not re-grant a unit in the cycle after its grant; this is enforced with a one-cycle per-unit mask grantedLast_r. This covers units that sample canGo late.
- Fairness: with all units requesting continuously, each unit is granted once per NUM_UNITS grants.
- Reset mid-operation clears the output register; any word in flight is lost. Units are reset by the same reset.

Optional Feature:
CDB_STATS_EN:
- Defined: adds outputs statGrants_o (32 bits) and statStalls_o (32 bits), both reset to 0.
  - statGrants_o increments on every grant.
  - statStalls_o increments each cycle where cdbValid_o=1, cdbReady_i=0 and unitValid_i!=0.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset_n_i=0 mid-cycle with unitValid_i=4'b1111 -> cdbValid_o=0 and canGo_o=0 immediately; after release, first grant is canGo_o=4'b0001.
- Single unit: unit 2 presents val=5, tag=3, commands=10, cdbReady_i=1 -> canGo_o=4'b0100 for one cycle; next cycle cdbValid_o=1, cdbVal_o=5, cdbTag_o=3, cdbCommands_o=10.
- Round-robin: all four requesting continuously, cdbReady_i=1 -> grant order 0,1,2,3,0,... with one grant per cycle, and the CDB sequence matches.
- Backpressure: hold cdbReady_i=0 for 5 cycles while FULL and units 1,3 requesting -> canGo_o=0 and CDB fields stable for 5 cycles; on release, unit 1 is granted the same cycle.
- Drain plus load: FULL with cdbReady_i=1 and unit 0 requesting -> cdbValid_o stays 1 and the next cycle shows unit 0's value with no bubble.
- With CDB_STATS_EN, 3 grants and 2 stall cycles -> statGrants_o=3, statStalls_o=2.
